// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a busy scoreboard for the decode stage.
//   Two write ports for dual writeback (port 1 wins an address collision),
//   NUM_RD combinational read ports with optional same-cycle write bypass,
//   and one busy bit per register that issue sets and writeback clears.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   we0/wa0/wd0       write port 0 (enable, address, data)
//   we1/wa1/wd1       write port 1 (enable, address, data)
//   ra / rd           flattened read addresses / read data, port k in slice k
//   rbusy             per read port: addressed register busy and not being written back
//   bset / baddr      busy-set strobe and target register from issue
//   busy_vec          raw scoreboard, bit i = register i busy
// Register 0 is hardwired: never written, never busy, always reads 0.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       bset,
  input  logic [ADDR_W-1:0]          baddr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wen0;
  logic              wen1;
  logic              bset_en;

  // Effective strobes: anything aimed at register 0 is dropped.
  assign wen0    = we0  && (wa0   != '0);
  assign wen1    = we1  && (wa1   != '0);
  assign bset_en = bset && (baddr != '0);

  // Scoreboard update: writeback clears, issue sets; set applied last so a new producer wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wen0)    busy_nxt[wa0]   = 1'b0;
    if (wen1)    busy_nxt[wa1]   = 1'b0;
    if (bset_en) busy_nxt[baddr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Storage and busy bits; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wen0 && !(wen1 && (wa1 == wa0))) mem[wa0] <= wd0;
      if (wen1)                            mem[wa1] <= wd1;
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  // Read ports: zero latency, forced to 0 while reset is held.
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic              hit0;
    logic              hit1;

    assign ra_k = ra[k*ADDR_W +: ADDR_W];
    assign hit0 = (BYPASS != 0) && wen0 && (wa0 == ra_k);
    assign hit1 = (BYPASS != 0) && wen1 && (wa1 == ra_k);

    always_comb begin
      rd[k*DATA_W +: DATA_W] = '0;
      if (rst_n && (ra_k != '0)) begin
        if (hit1)      rd[k*DATA_W +: DATA_W] = wd1;
        else if (hit0) rd[k*DATA_W +: DATA_W] = wd0;
        else           rd[k*DATA_W +: DATA_W] = mem[ra_k];
      end
    end

    // A register being written back this cycle is already resolved when bypass is on.
    assign rbusy[k] = rst_n && busy_q[ra_k] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two instances share the write/issue inputs -- u_a (NUM_RD=4, BYPASS=1)
// and u_b (NUM_RD=2, BYPASS=0) -- and are checked against an array-based model.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we0, we1, bset;
  logic [4:0]   wa0, wa1, baddr;
  logic [31:0]  wd0, wd1;
  logic [19:0]  ra_a;
  logic [9:0]   ra_b;
  logic [127:0] rd_a;
  logic [63:0]  rd_b;
  logic [3:0]   rbusy_a;
  logic [1:0]   rbusy_b;
  logic [31:0]  busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .bset(bset), .baddr(baddr), .busy_vec(busy_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .bset(bset), .baddr(baddr), .busy_vec(busy_b)
  );

  // Expected read value for the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input logic [4:0] a, input bit byp);
    bit wb;
    wb = (we0 && wa0 == a) || (we1 && wa1 == a);
    return (a != 5'd0) && m_busy[a] && !(byp && wb);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_busy = 32'd0;
  endtask

  // Apply one clock edge to the model, in priority order.
  task automatic model_edge();
    if (we0 && wa0 != 5'd0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
    if (we1 && wa1 != 5'd0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
    if (bset && baddr != 5'd0) m_busy[baddr] = 1'b1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
    bset = 1'b0; baddr = 5'd0;
  endtask

  // Advance one clock; inputs change and outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); ra_a = '0; ra_b = '0;
    model_clear();
    repeat (2) tick();
    rst_n = 1'b1; tick();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h5555_0005;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h3333_0003;
    bset = 1'b1; baddr = 5'd6;
    tick(); idle();
    ra_a = {5'd6, 5'd0, 5'd3, 5'd5}; ra_b = {5'd3, 5'd5};
    #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'h5555_0005) begin
      n_err++; $display("FAIL preload_r5 got %h want %h", rd_a[31:0], 32'h5555_0005);
    end
    // Mid-cycle reset with a write and a bset pending.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hFFFF_FFFF; bset = 1'b1; baddr = 5'd7;
    rst_n = 1'b0; model_clear();
    #1;
    n_cmp++;
    if (rd_a !== 128'd0) begin n_err++; $display("FAIL reset_rd_a got %h want 0", rd_a); end
    n_cmp++;
    if (rd_b !== 64'd0) begin n_err++; $display("FAIL reset_rd_b got %h want 0", rd_b); end
    n_cmp++;
    if (busy_a !== 32'd0 || busy_b !== 32'd0) begin
      n_err++; $display("FAIL reset_busy got %h/%h want 0", busy_a, busy_b);
    end
    n_cmp++;
    if (rbusy_a !== 4'd0 || rbusy_b !== 2'd0) begin
      n_err++; $display("FAIL reset_rbusy got %b/%b want 0", rbusy_a, rbusy_b);
    end
    tick(); tick();
    idle(); rst_n = 1'b1;
    tick();
    #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'd0) begin n_err++; $display("FAIL post_reset_r5 got %h want 0", rd_a[31:0]); end
    n_cmp++;
    if (busy_a !== 32'd0) begin n_err++; $display("FAIL post_reset_busy got %h want 0", busy_a); end
  endtask

  task automatic test_write_read();
    idle();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF;
    ra_a = {15'd0, 5'd3}; ra_b = {5'd0, 5'd3};
    #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_bypass got %h want deadbeef", rd_a[31:0]); end
    n_cmp++;
    if (rd_b[31:0] !== 32'd0) begin n_err++; $display("FAIL wr_nobypass_same got %h want 0", rd_b[31:0]); end
    tick(); idle(); #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_read_a got %h want deadbeef", rd_a[31:0]); end
    n_cmp++;
    if (rd_b[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_read_b got %h want deadbeef", rd_b[31:0]); end
    // Register 0 ignores writes, including the bypass path.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h0000_1234;
    ra_a = 20'd0; ra_b = 10'd0;
    #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'd0) begin n_err++; $display("FAIL r0_bypass got %h want 0", rd_a[31:0]); end
    tick(); idle(); #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'd0 || rd_b[31:0] !== 32'd0) begin
      n_err++; $display("FAIL r0_read got %h/%h want 0", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_dual_conflict();
    idle();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    ra_a = {15'd0, 5'd7}; ra_b = {5'd0, 5'd7};
    #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'h22) begin n_err++; $display("FAIL dual_bypass got %h want 22", rd_a[31:0]); end
    tick(); idle(); #2;
    n_cmp++;
    if (rd_a[31:0] !== 32'h22) begin n_err++; $display("FAIL dual_stored_a got %h want 22", rd_a[31:0]); end
    n_cmp++;
    if (rd_b[31:0] !== 32'h22) begin n_err++; $display("FAIL dual_stored_b got %h want 22", rd_b[31:0]); end
  endtask

  task automatic test_bypass_off();
    idle();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hA5A5_A5A5;
    ra_b = {5'd9, 5'd9};
    #2;
    n_cmp++;
    if (rd_b !== 64'd0) begin n_err++; $display("FAIL nobyp_same got %h want 0", rd_b); end
    tick(); idle(); #2;
    n_cmp++;
    if (rd_b !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
      n_err++; $display("FAIL nobyp_next got %h want a5a5a5a5a5a5a5a5", rd_b);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    ra_a = {15'd0, 5'd4}; ra_b = {5'd0, 5'd4};
    bset = 1'b1; baddr = 5'd4;
    tick(); idle(); #2;
    n_cmp++;
    if (busy_a[4] !== 1'b1) begin n_err++; $display("FAIL sb_set got %b want 1", busy_a[4]); end
    n_cmp++;
    if (rbusy_a[0] !== 1'b1) begin n_err++; $display("FAIL sb_rbusy got %b want 1", rbusy_a[0]); end
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h4444;
    #2;
    n_cmp++;
    if (rbusy_a[0] !== 1'b0) begin n_err++; $display("FAIL sb_wb_byp got %b want 0", rbusy_a[0]); end
    n_cmp++;
    if (rbusy_b[0] !== 1'b1) begin n_err++; $display("FAIL sb_wb_nobyp got %b want 1", rbusy_b[0]); end
    tick(); idle(); #2;
    n_cmp++;
    if (busy_a[4] !== 1'b0) begin n_err++; $display("FAIL sb_clear got %b want 0", busy_a[4]); end
    // Set and writeback on the same edge: set wins. bset to r0 is ignored.
    bset = 1'b1; baddr = 5'd4; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h4545;
    tick();
    bset = 1'b1; baddr = 5'd0; we1 = 1'b0;
    tick(); idle(); #2;
    n_cmp++;
    if (busy_a[4] !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got %b want 1", busy_a[4]); end
    n_cmp++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
      n_err++; $display("FAIL sb_r0 got %b/%b want 0", busy_a[0], busy_b[0]);
    end
  endtask

  task automatic test_multi_port();
    idle();
    we0 = 1'b1; wa0 = 5'd31; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd1;  wd1 = 32'h1;
    tick(); idle();
    ra_a = {5'd31, 5'd0, 5'd1, 5'd31};
    #2;
    n_cmp++;
    if (rd_a !== {32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL multi_port got %h", rd_a);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      bset = 1'($urandom_range(0, 2) == 0);
      // Narrow address pool half the time to force collisions.
      if ($urandom_range(0, 1) == 0) begin
        wa0 = 5'($urandom_range(0, 5)); wa1 = 5'($urandom_range(0, 5));
        baddr = 5'($urandom_range(0, 5)); ra_a = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                                                   5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
        ra_b = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
      end else begin
        wa0 = 5'($urandom); wa1 = 5'($urandom); baddr = 5'($urandom);
        ra_a = 20'($urandom); ra_b = 10'($urandom);
      end
      wd0 = $urandom; wd1 = $urandom;
      #2;
      for (int k = 0; k < 4; k++) begin
        a = ra_a[k*5 +: 5];
        n_cmp++;
        if (rd_a[k*32 +: 32] !== exp_rd(a, 1'b1)) begin
          n_err++; $display("FAIL rnd_rd_a%0d cyc %0d addr %0d got %h want %h", k, c, a, rd_a[k*32 +: 32], exp_rd(a, 1'b1));
        end
        n_cmp++;
        if (rbusy_a[k] !== exp_rb(a, 1'b1)) begin
          n_err++; $display("FAIL rnd_rbusy_a%0d cyc %0d addr %0d got %b want %b", k, c, a, rbusy_a[k], exp_rb(a, 1'b1));
        end
      end
      for (int k = 0; k < 2; k++) begin
        a = ra_b[k*5 +: 5];
        n_cmp++;
        if (rd_b[k*32 +: 32] !== exp_rd(a, 1'b0)) begin
          n_err++; $display("FAIL rnd_rd_b%0d cyc %0d addr %0d got %h want %h", k, c, a, rd_b[k*32 +: 32], exp_rd(a, 1'b0));
        end
        n_cmp++;
        if (rbusy_b[k] !== exp_rb(a, 1'b0)) begin
          n_err++; $display("FAIL rnd_rbusy_b%0d cyc %0d addr %0d got %b want %b", k, c, a, rbusy_b[k], exp_rb(a, 1'b0));
        end
      end
      n_cmp++;
      if (busy_a !== m_busy || busy_b !== m_busy) begin
        n_err++; $display("FAIL rnd_busy_vec cyc %0d got %h/%h want %h", c, busy_a, busy_b, m_busy);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_conflict();
    test_bypass_off();
    test_scoreboard();
    test_multi_port();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-port successor to the single-write CPU register file.
- Two write ports for the dual-writeback pipeline, NUM_RD combinational read ports, optional write-to-read bypass, and a per-register busy scoreboard for the hazard unit.
- Sits in the decode stage. Writeback drives the write ports; issue drives the busy-set port.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
ra  in  NUM_RD*ADDR_W  read addresses, flattened; port k = ra[k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data, flattened, same slicing as ra
rbusy  out  NUM_RD  busy flag per read port
bset  in  1  busy-set strobe from issue
baddr  in  ADDR_W  register to mark busy
busy_vec  out  2**ADDR_W  raw scoreboard state, bit i = register i busy

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All registers clear to 0 and all busy bits clear to 0.
  - rd and rbusy go to 0 for every address while reset is held.
  - Reset asserted mid-cycle overrides any write or bset on that edge.
- Register 0:
  - Never written and never busy.
  - Reads of address 0 return 0 and rbusy = 0 regardless of we/bset.
- Writes, on the rising edge:
  - wd0 is stored to wa0 when we0 = 1 and wa0 != 0; same for port 1.
  - If both ports write the same nonzero address, port 1 wins; port 0's data is discarded.
- Reads are combinational, zero latency.
- Bypass:
  - BYPASS = 1: if the read address equals a write address with its enable set this cycle, rd returns that write data instead of the stored value. When both ports match, wd1 is returned, consistent with the write priority.
  - BYPASS = 0: rd returns the stored value; new data is visible the cycle after the edge.
- Scoreboard, evaluated on the rising edge:
  - bset = 1 with baddr != 0 sets busy[baddr].
  - Any enabled write to a nonzero address clears busy for that address.
  - If bset and a write hit the same address on the same edge, set wins (new producer issued).
  - bset with baddr = 0 is ignored.
- rbusy[k]:
  - Computed as busy[ra_k] AND NOT (BYPASS and an enabled write to ra_k this cycle).
  - So a register being written back this cycle is not reported busy when bypass is on.
- No X propagation: unwritten registers read 0 after reset.
- Implementation: a single always block with async reset for storage plus busy bits, and a generate loop over read ports.

Test Plan:
- Reset check: preload via writes, assert rst_n = 0 mid-cycle -> all rd = 0 immediately, busy_vec = 0; after release, reading r5 gives 0.
- Basic write/read: we0 = 1, wa0 = 3, wd0 = 0xDEADBEEF; next cycle ra port0 = 3 -> rd0 = 0xDEADBEEF. Write to r0 with 0x1234 -> read r0 = 0.
- Dual-write conflict: we0 = we1 = 1, wa0 = wa1 = 7, wd0 = 0x11, wd1 = 0x22 -> r7 = 0x22 after the edge. With BYPASS = 1, the same-cycle read of r7 = 0x22.
- Bypass off: BYPASS = 0, write r9 = 0xA5A5A5A5 while reading r9 holding 0 -> rd = 0 that cycle, 0xA5A5A5A5 the next.
- Scoreboard:
  - bset baddr = 4 -> busy_vec[4] = 1 and rbusy = 1 on ra = 4.
  - Write r4 the next cycle -> rbusy = 0 during that cycle (BYPASS = 1); busy_vec[4] = 0 after the edge.
  - bset and write both on r4 in the same cycle -> busy_vec[4] stays 1.
- Multi-port and edge addresses: NUM_RD = 4; write r31 = 0xFFFFFFFF and r1 = 0x1; read ports = {31, 1, 0, 31} -> {0xFFFFFFFF, 0x1, 0, 0xFFFFFFFF}.
